alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, operand/result width in bits, matching the shared alu instance.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  N each  operands.
REQ-007 SHALL have ports req0_sel / req1_sel  input  4 each  ALU opcode: 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SL, 0101 SR.
REQ-008 SHALL have ports alu_a, alu_b  output  N each, and alu_sel  output  4; all registered, driving the shared alu A/B/sel.
REQ-009 SHALL have ports alu_result  input  N, and alu_of, alu_carry, alu_cero, alu_neg  input  1 each; combinational alu outputs.
REQ-010 SHALL have port rsp_valid  output  1, and rsp_ready  input  1; response handshake.
REQ-011 SHALL have ports rsp_id  output  1 (requester index), rsp_result  output  N, rsp_of, rsp_carry, rsp_cero, rsp_neg, rsp_err  output  1 each.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 In IDLE, SHALL grant one valid requester: only one valid -> that one; both valid -> the one selected by the round-robin pointer.
REQ-014 SHALL assert reqX_ready combinationally only in IDLE and only for the granted requester; at most one ready high per cycle.
REQ-015 On accept (valid & ready), SHALL register operands/opcode into alu_a/alu_b/alu_sel, store the requester index, and go to EXEC.
REQ-016 In EXEC (exactly one cycle), SHALL capture alu_result and the four flags into rsp_* registers and go to RESP.
REQ-017 In RESP, SHALL hold rsp_valid=1 and all rsp_* stable until rsp_ready=1; on that cycle go to IDLE.
REQ-018 Latency: accept at cycle t -> rsp_valid first high at t+2; minimum issue interval 3 cycles (rsp_ready tied high).
REQ-019 Round-robin pointer SHALL be 0 after reset and be set to the other requester index when the response handshake completes.
REQ-020 Opcode > 0101 SHALL still follow IDLE->EXEC->RESP, with rsp_err=1, rsp_result=0, all rsp flags 0; valid opcodes give rsp_err=0.
REQ-021 alu_a/alu_b/alu_sel SHALL hold their last values outside EXEC.
REQ-022 reqX_ready SHALL be 0 in EXEC and RESP regardless of valid; pending requests wait without loss.
REQ-023 Requester deasserting valid while not granted SHALL have no effect on state.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, pointer=0, alu_a=alu_b=0, alu_sel=0000, rsp_valid=0, rsp_id=0, rsp_result=0, all rsp flags and rsp_err=0.
REQ-025 reqX_ready SHALL be 0 during any cycle with rst=1.
REQ-026 Reset in EXEC or RESP SHALL abandon the in-flight operation; no response issued afterward.

Verification
REQ-027 req0 ADD a=0100 b=0010, rsp_ready=1 -> rsp_valid at t+2, rsp_id=0, rsp_result=0110, all flags 0, err 0.
REQ-028 Both valid after reset (req0 AND 1010&1100, req1 XOR 0101^0011) -> req0 first (1000), then req1 (0110); next tie grants req0 again.
REQ-029 req1 ADD 0111+0001 -> rsp_result=1000, rsp_of=1, rsp_neg=1, rsp_cero=0.
REQ-030 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both readies 0, no new accept until handshake.
REQ-031 req0_sel=1111 -> rsp_err=1, rsp_result=0000, flags 0, FSM returns to IDLE.
REQ-032 rst=1 during RESP -> next cycle rsp_valid=0, pointer=0, pending req0 accepted after rst drops.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. Each accepted
// operation takes one pass through IDLE -> EXEC -> RESP:
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; grant one requester and latch its operands
//   EXEC  | ALU inputs are stable; capture result and flags into rsp_*
//   RESP  | rsp_valid high; hold rsp_* until rsp_ready, then return to IDLE
//
// Ties between the requesters are broken by a round-robin pointer. The pointer
// moves to the other requester only when a response handshake completes, so
// an abandoned operation (reset mid-flight) never changes fairness.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req0_* / req1_*           valid/ready handshake, operands a/b, opcode sel
//   alu_a, alu_b, alu_sel     registered drive into the shared ALU
//   alu_result, alu_of,
//   alu_carry, alu_cero,
//   alu_neg                   combinational ALU outputs
//   rsp_valid, rsp_ready      response handshake
//   rsp_id                    index of the requester the response belongs to
//   rsp_result, rsp_of,
//   rsp_carry, rsp_cero,
//   rsp_neg, rsp_err          captured result, flags and bad-opcode indication
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_sel,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_sel,

    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_result,
    input  logic         alu_of,
    input  logic         alu_carry,
    input  logic         alu_cero,
    input  logic         alu_neg,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_of,
    output logic         rsp_carry,
    output logic         rsp_cero,
    output logic         rsp_neg,
    output logic         rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_LAST = 4'b0101;

    state_t state;
    state_t state_nxt;

    logic   ptr;        // requester favoured on a tie
    logic   id_q;       // requester owning the in-flight operation
    logic   grant_any;
    logic   grant_id;
    logic   accept;
    logic   op_err;

    // Grant selection: a lone valid requester wins outright, a tie goes to ptr.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ptr;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is gated by rst so nothing is handshaken during a reset cycle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        if (state == IDLE && !rst && grant_any) begin
            accept     = 1'b1;
            req0_ready = ~grant_id;
            req1_ready = grant_id;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign op_err    = (alu_sel > OP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            id_q       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= 4'b0000;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_of     <= 1'b0;
            rsp_carry  <= 1'b0;
            rsp_cero   <= 1'b0;
            rsp_neg    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;

            // ALU inputs only change on accept, so they hold through EXEC/RESP.
            if (accept) begin
                alu_a   <= grant_id ? req1_a   : req0_a;
                alu_b   <= grant_id ? req1_b   : req0_b;
                alu_sel <= grant_id ? req1_sel : req0_sel;
                id_q    <= grant_id;
            end

            if (state == EXEC) begin
                rsp_id <= id_q;
                if (op_err) begin
                    // Whatever the ALU drives for an unknown opcode is ignored.
                    rsp_result <= '0;
                    rsp_of     <= 1'b0;
                    rsp_carry  <= 1'b0;
                    rsp_cero   <= 1'b0;
                    rsp_neg    <= 1'b0;
                    rsp_err    <= 1'b1;
                end else begin
                    rsp_result <= alu_result;
                    rsp_of     <= alu_of;
                    rsp_carry  <= alu_carry;
                    rsp_cero   <= alu_cero;
                    rsp_neg    <= alu_neg;
                    rsp_err    <= 1'b0;
                end
            end

            if (state == RESP && rsp_ready) begin
                ptr <= ~rsp_id;
            end
        end
    end

endmodule
